ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline register plus execute-stage operand selection; drives ALUop1/ALUop2/ALUctrl of the ALU directly.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and stalls decode while inserting one bubble.
- Honours branch-flush from the ALU EQ path.

Parameters:
DATA_WIDTH, 32, datapath width
ALU_CTRL_WIDTH, 3, ALU control field width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a real instruction
id_rd1  in  DATA_WIDTH  regfile read data for rs1
id_rd2  in  DATA_WIDTH  regfile read data for rs2
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1  in  REG_ADDR_WIDTH  source index 1
id_rs2  in  REG_ADDR_WIDTH  source index 2
id_rd  in  REG_ADDR_WIDTH  destination index
id_alu_ctrl  in  ALU_CTRL_WIDTH  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
id_alu_src  in  1  1 = op2 from immediate
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
id_uses_rs2  in  1  rs2 is a true source (R-type, store, branch)
flush  in  1  branch taken; kill instruction entering EX
m_rd  in  REG_ADDR_WIDTH  MEM-stage destination
m_reg_write  in  1  MEM-stage writes rd
m_result  in  DATA_WIDTH  MEM-stage ALU result
w_rd  in  REG_ADDR_WIDTH  WB-stage destination
w_reg_write  in  1  WB-stage writes rd
w_result  in  DATA_WIDTH  WB-stage final result
ALUop1  out  DATA_WIDTH  ALU operand 1
ALUop2  out  DATA_WIDTH  ALU operand 2
ALUctrl  out  ALU_CTRL_WIDTH  ALU control
ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
ex_rd  out  REG_ADDR_WIDTH  EX destination
ex_reg_write  out  1  EX writes rd (0 when bubble)
ex_mem_read  out  1  EX is a load (0 when bubble)
ex_valid  out  1  EX holds a real instruction
stall_d  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Reset: every EX register cleared. ex_valid, ex_reg_write, ex_mem_read = 0; ALUctrl = 000; ex_rd = 0. Stored operands and immediate = 0, so ALUop1 = ALUop2 = ex_store_data = 0 when no forward hits.
- Load-use detect (combinational, on registered EX state):
  - Condition: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
  - stall_d = 1 when the condition holds, else 0.
- Register update priority each edge: rst > flush > stall_d > normal.
  - flush or stall_d: load a bubble. ex_valid, ex_reg_write, ex_mem_read = 0; ALUctrl = 000. Datapath registers are don't-care but hold their values.
  - Normal: capture all id_* fields; ex_valid <= id_valid. If id_valid=0, reg_write and mem_read are captured as 0.
  - flush and stall_d together: a single bubble. The upstream stall is also overridden by the flush at IF/ID (outside this block).
- Forwarding, rs1 (combinational, zero latency), highest priority first:
  1. MEM hit: m_reg_write & m_rd!=0 & m_rd==rs1_e.
  2. WB hit: w_reg_write & w_rd!=0 & w_rd==rs1_e.
  3. Otherwise the stored rd1.
- Forwarding, rs2: same priority rule produces fwd2.
- Register x0 is never forwarded.
- ALUop1 = fwd1. ALUop2 = alu_src_e ? imm_e : fwd2. ex_store_data = fwd2 always.
- Latency: one cycle from id_* to EX outputs. Forwarding adds no cycles.
- The stall lasts exactly one cycle: the bubble clears ex_mem_read next cycle, and the load then forwards from WB two stages later.
- Reset asserted mid-stall: stall_d drops on the cycle after reset, because ex_valid=0.

Optional Feature:
EX_HAZARD_CNT_EN
- Defined: adds outputs stall_cnt and flush_cnt, each 32 bits.
  - stall_cnt increments on each cycle with stall_d=1 and no flush.
  - flush_cnt increments on each cycle with flush=1.
  - Both saturate at all-ones and clear on rst.
- Undefined: counters and ports absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary id_* -> ex_valid=0, ALUctrl=000, ALUop1=ALUop2=0, stall_d=0.
- MEM forward: EX add rs1=x5; m_rd=5, m_reg_write=1, m_result=0x0000_0011; id_rd1 was 0x3 -> ALUop1=0x11.
- Priority: m_rd=w_rd=6, m_result=0xAA, w_result=0xBB, rs2_e=6, alu_src=0 -> ALUop2=0xAA. Repeat with m_rd=0 -> ALUop2=0xBB.
- x0 guard: m_rd=0, m_reg_write=1, m_result=0xFFFF_FFFF, rs1_e=0, id_rd1=0 -> ALUop1=0.
- Load-use: EX lw x7; decode add x8,x7,x1 -> stall_d=1 for exactly 1 cycle. Next cycle ex_valid=0 and ex_reg_write=0. Following cycle add enters EX and ALUop1 = w_result.
- Flush: flush=1 with id_valid=1 and id_reg_write=1 -> next cycle ex_valid=0 and ex_reg_write=0. With EX_HAZARD_CNT_EN, flush_cnt increments 0->1.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// Decode/EX/MEM/WB signal bundle for the execute operand stage.
// master = pipeline side that drives decode and writeback state; slave = the stage itself.
interface ex_operand_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int REG_ADDR_WIDTH = 5
) ();
  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_rd1;
  logic [DATA_WIDTH-1:0]     id_rd2;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [ALU_CTRL_WIDTH-1:0] id_alu_ctrl;
  logic                      id_alu_src;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_uses_rs2;
  logic                      flush;
  logic [REG_ADDR_WIDTH-1:0] m_rd;
  logic                      m_reg_write;
  logic [DATA_WIDTH-1:0]     m_result;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic                      w_reg_write;
  logic [DATA_WIDTH-1:0]     w_result;
  logic [DATA_WIDTH-1:0]     ALUop1;
  logic [DATA_WIDTH-1:0]     ALUop2;
  logic [ALU_CTRL_WIDTH-1:0] ALUctrl;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_valid;
  logic                      stall_d;

  modport master (
    output id_valid, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_alu_ctrl,
           id_alu_src, id_reg_write, id_mem_read, id_uses_rs2, flush,
           m_rd, m_reg_write, m_result, w_rd, w_reg_write, w_result,
    input  ALUop1, ALUop2, ALUctrl, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_valid, stall_d
  );

  modport slave (
    input  id_valid, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_alu_ctrl,
           id_alu_src, id_reg_write, id_mem_read, id_uses_rs2, flush,
           m_rd, m_reg_write, m_result, w_rd, w_reg_write, w_result,
    output ALUop1, ALUop2, ALUctrl, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_valid, stall_d
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX register with MEM/WB operand forwarding and load-use stall detection.
// Define EX_HAZARD_CNT_EN to add saturating stall_cnt/flush_cnt event counters.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  ex_operand_stage_if.slave   bus
`ifdef EX_HAZARD_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
`endif
);
  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_read;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
    logic                      alu_src;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
  } ex_t;

  ex_t                   ex_q, ex_d;
  logic                  stall;
  logic [DATA_WIDTH-1:0] fwd1, fwd2;

  // MEM beats WB because it carries the younger write; x0 is never forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0]     stored,
    input logic [REG_ADDR_WIDTH-1:0] m_rd,
    input logic                      m_we,
    input logic [DATA_WIDTH-1:0]     m_res,
    input logic [REG_ADDR_WIDTH-1:0] w_rd,
    input logic                      w_we,
    input logic [DATA_WIDTH-1:0]     w_res
  );
    if (m_we && (m_rd != '0) && (m_rd == rs))      return m_res;
    else if (w_we && (w_rd != '0) && (w_rd == rs)) return w_res;
    else                                           return stored;
  endfunction

  assign stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
                 ((ex_q.rd == bus.id_rs1) || (bus.id_uses_rs2 && (ex_q.rd == bus.id_rs2)));

  always_comb begin
    ex_d = ex_q;
    if (bus.flush || stall) begin
      // Bubble: kill control, leave datapath fields as they were.
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.alu_ctrl  = '0;
    end else begin
      ex_d.valid     = bus.id_valid;
      ex_d.reg_write = bus.id_valid && bus.id_reg_write;
      ex_d.mem_read  = bus.id_valid && bus.id_mem_read;
      ex_d.alu_ctrl  = bus.id_alu_ctrl;
      ex_d.alu_src   = bus.id_alu_src;
      ex_d.rd        = bus.id_rd;
      ex_d.rs1       = bus.id_rs1;
      ex_d.rs2       = bus.id_rs2;
      ex_d.rd1       = bus.id_rd1;
      ex_d.rd2       = bus.id_rd2;
      ex_d.imm       = bus.id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign fwd1 = fwd_sel(ex_q.rs1, ex_q.rd1, bus.m_rd, bus.m_reg_write, bus.m_result,
                        bus.w_rd, bus.w_reg_write, bus.w_result);
  assign fwd2 = fwd_sel(ex_q.rs2, ex_q.rd2, bus.m_rd, bus.m_reg_write, bus.m_result,
                        bus.w_rd, bus.w_reg_write, bus.w_result);

  assign bus.ALUop1        = fwd1;
  assign bus.ALUop2        = ex_q.alu_src ? ex_q.imm : fwd2;
  assign bus.ALUctrl       = ex_q.alu_ctrl;
  assign bus.ex_store_data = fwd2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.stall_d       = stall;

`ifdef EX_HAZARD_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // A flush overrides a stall in the same cycle, so only unflushed stalls count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !bus.flush && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.flush && (flush_cnt_q != '1))           flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: each driven cycle pushes the expected EX
// contents; the next cycle pops them and checks outputs with forwarding from current MEM/WB.
`timescale 1ns/1ps
module tb_ex_operand_stage;
  localparam int DW = 32, ACW = 3, RAW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(ACW), .REG_ADDR_WIDTH(RAW)) bus ();
`ifdef EX_HAZARD_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  ex_operand_stage #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(ACW), .REG_ADDR_WIDTH(RAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef EX_HAZARD_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic           rst, flush, id_valid;
    logic [DW-1:0]  rd1, rd2, imm;
    logic [RAW-1:0] rs1, rs2, rd;
    logic [ACW-1:0] ctrl;
    logic           alu_src, reg_write, mem_read, uses_rs2;
    logic [RAW-1:0] m_rd;
    logic           m_rw;
    logic [DW-1:0]  m_res;
    logic [RAW-1:0] w_rd;
    logic           w_rw;
    logic [DW-1:0]  w_res;
  } stim_t;

  typedef struct packed {
    logic           valid, rw, mr;
    logic [ACW-1:0] ctrl;
    logic           alu_src;
    logic [RAW-1:0] rd, rs1, rs2;
    logic [DW-1:0]  rd1, rd2, imm;
  } exp_t;

  stim_t       s;
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_stall_cnt = '0, m_flush_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input logic [RAW-1:0] rs, input logic [DW-1:0] stored);
    if (s.m_rw && s.m_rd != 0 && s.m_rd == rs) return s.m_res;
    if (s.w_rw && s.w_rd != 0 && s.w_rd == rs) return s.w_res;
    return stored;
  endfunction

  task automatic nop();
    s = '0;
  endtask

  task automatic set_instr(input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                           input logic [RAW-1:0] rd, input logic [DW-1:0] rd1,
                           input logic [DW-1:0] rd2, input logic [ACW-1:0] ctrl);
    s.id_valid = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.rd1 = rd1; s.rd2 = rd2; s.ctrl = ctrl;
    s.reg_write = 1'b1; s.uses_rs2 = 1'b1;
  endtask

  task automatic cycle();
    exp_t e, n;
    logic stall;
    logic [DW-1:0] f2;
    @(negedge clk);
    rst              = s.rst;
    bus.flush        = s.flush;
    bus.id_valid     = s.id_valid;
    bus.id_rd1       = s.rd1;
    bus.id_rd2       = s.rd2;
    bus.id_imm       = s.imm;
    bus.id_rs1       = s.rs1;
    bus.id_rs2       = s.rs2;
    bus.id_rd        = s.rd;
    bus.id_alu_ctrl  = s.ctrl;
    bus.id_alu_src   = s.alu_src;
    bus.id_reg_write = s.reg_write;
    bus.id_mem_read  = s.mem_read;
    bus.id_uses_rs2  = s.uses_rs2;
    bus.m_rd         = s.m_rd;
    bus.m_reg_write  = s.m_rw;
    bus.m_result     = s.m_res;
    bus.w_rd         = s.w_rd;
    bus.w_reg_write  = s.w_rw;
    bus.w_result     = s.w_res;
    #1;
    e = '0;
    stall = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      stall = e.valid && e.mr && e.rd != 0 && s.id_valid &&
              (e.rd == s.rs1 || (s.uses_rs2 && e.rd == s.rs2));
      f2 = fwd(e.rs2, e.rd2);
      chk("ex_valid", bus.ex_valid, e.valid);
      chk("ex_reg_write", bus.ex_reg_write, e.rw);
      chk("ex_mem_read", bus.ex_mem_read, e.mr);
      chk("ALUctrl", bus.ALUctrl, e.ctrl);
      chk("ex_rd", bus.ex_rd, e.rd);
      chk("ALUop1", bus.ALUop1, fwd(e.rs1, e.rd1));
      chk("ALUop2", bus.ALUop2, e.alu_src ? e.imm : f2);
      chk("ex_store_data", bus.ex_store_data, f2);
      chk("stall_d", bus.stall_d, stall);
`ifdef EX_HAZARD_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall_cnt);
      chk("flush_cnt", flush_cnt, m_flush_cnt);
`endif
    end
    if (s.rst) n = '0;
    else if (s.flush || stall) begin
      n = e; n.valid = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.ctrl = '0;
    end else begin
      n.valid = s.id_valid; n.rw = s.id_valid & s.reg_write; n.mr = s.id_valid & s.mem_read;
      n.ctrl = s.ctrl; n.alu_src = s.alu_src; n.rd = s.rd; n.rs1 = s.rs1; n.rs2 = s.rs2;
      n.rd1 = s.rd1; n.rd2 = s.rd2; n.imm = s.imm;
    end
    sb.push_back(n);
    if (s.rst) begin
      m_stall_cnt = '0; m_flush_cnt = '0;
    end else begin
      if (stall && !s.flush && m_stall_cnt != '1) m_stall_cnt++;
      if (s.flush && m_flush_cnt != '1) m_flush_cnt++;
    end
  endtask

  initial begin
    // Reset for two cycles with junk on decode.
    nop(); s.rst = 1'b1; set_instr(5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b011);
    s.mem_read = 1'b1; s.imm = 32'h1234;
    cycle(); cycle();
    nop(); cycle();
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ALUctrl", bus.ALUctrl, 3'b000);
    chk("rst_ALUop1", bus.ALUop1, 32'h0);
    chk("rst_ALUop2", bus.ALUop2, 32'h0);
    chk("rst_stall_d", bus.stall_d, 1'b0);

    // MEM forward onto rs1.
    nop(); set_instr(5'd5, 5'd0, 5'd9, 32'h3, 32'h0, 3'b000); cycle();
    nop(); s.m_rd = 5'd5; s.m_rw = 1'b1; s.m_res = 32'h11; cycle();
    chk("mem_fwd_op1", bus.ALUop1, 32'h11);

    // MEM has priority over WB, WB used when MEM targets x0.
    nop(); set_instr(5'd1, 5'd6, 5'd10, 32'h7, 32'h1, 3'b001); cycle();
    s.m_rd = 5'd6; s.m_rw = 1'b1; s.m_res = 32'hAA;
    s.w_rd = 5'd6; s.w_rw = 1'b1; s.w_res = 32'hBB; cycle();
    chk("prio_mem_op2", bus.ALUop2, 32'hAA);
    s.m_rd = 5'd0; cycle();
    chk("prio_wb_op2", bus.ALUop2, 32'hBB);

    // x0 is never forwarded.
    nop(); set_instr(5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 3'b010); cycle();
    nop(); s.m_rd = 5'd0; s.m_rw = 1'b1; s.m_res = 32'hFFFF_FFFF;
    s.w_rd = 5'd0; s.w_rw = 1'b1; s.w_res = 32'hFFFF_FFFF; cycle();
    chk("x0_op1", bus.ALUop1, 32'h0);

    // Load-use: lw x7 then add x8,x7,x1.
    nop(); set_instr(5'd2, 5'd0, 5'd7, 32'h100, 32'h0, 3'b000);
    s.uses_rs2 = 1'b0; s.mem_read = 1'b1; s.alu_src = 1'b1; s.imm = 32'h4; cycle();
    nop(); set_instr(5'd7, 5'd1, 5'd8, 32'h55, 32'h66, 3'b000); cycle();
    chk("lu_stall", bus.stall_d, 1'b1);
    s.m_rd = 5'd7; s.m_rw = 1'b1; s.m_res = 32'h104; cycle();
    chk("lu_bubble_valid", bus.ex_valid, 1'b0);
    chk("lu_bubble_rw", bus.ex_reg_write, 1'b0);
    chk("lu_stall_once", bus.stall_d, 1'b0);
    nop(); s.w_rd = 5'd7; s.w_rw = 1'b1; s.w_res = 32'h1234; cycle();
    chk("lu_wb_fwd", bus.ALUop1, 32'h1234);
    chk("lu_add_valid", bus.ex_valid, 1'b1);

    // Flush kills the entering instruction.
    nop(); set_instr(5'd1, 5'd2, 5'd12, 32'h9, 32'hA, 3'b101); s.flush = 1'b1; cycle();
    nop(); cycle();
    chk("flush_valid", bus.ex_valid, 1'b0);
    chk("flush_rw", bus.ex_reg_write, 1'b0);
`ifdef EX_HAZARD_CNT_EN
    chk("flush_cnt_one", flush_cnt, 32'd1);
`endif

    // Reset asserted while a load-use stall is active.
    nop(); set_instr(5'd1, 5'd0, 5'd3, 32'h1, 32'h0, 3'b000); s.mem_read = 1'b1; cycle();
    nop(); set_instr(5'd3, 5'd3, 5'd4, 32'h2, 32'h2, 3'b000); s.rst = 1'b1; cycle();
    chk("rst_mid_stall_hi", bus.stall_d, 1'b1);
    s.rst = 1'b0; cycle();
    chk("rst_mid_stall_lo", bus.stall_d, 1'b0);

    // Random traffic over a small register window to provoke hits and hazards.
    for (int i = 0; i < 80; i++) begin
      nop();
      s.rst       = ($urandom_range(0, 29) == 0);
      s.flush     = ($urandom_range(0, 7) == 0);
      s.id_valid  = ($urandom_range(0, 5) != 0);
      s.rs1       = RAW'($urandom_range(0, 3));
      s.rs2       = RAW'($urandom_range(0, 3));
      s.rd        = RAW'($urandom_range(0, 3));
      s.rd1       = $urandom; s.rd2 = $urandom; s.imm = $urandom;
      s.ctrl      = ACW'($urandom_range(0, 7));
      s.alu_src   = $urandom_range(0, 1) != 0;
      s.reg_write = $urandom_range(0, 1) != 0;
      s.mem_read  = $urandom_range(0, 2) == 0;
      s.uses_rs2  = $urandom_range(0, 1) != 0;
      s.m_rd      = RAW'($urandom_range(0, 3)); s.m_rw = $urandom_range(0, 1) != 0; s.m_res = $urandom;
      s.w_rd      = RAW'($urandom_range(0, 3)); s.w_rw = $urandom_range(0, 1) != 0; s.w_res = $urandom;
      cycle();
    end
    nop(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
